// File: rtl/sram_sched_pkg.sv
// Shared state encoding, default geometry and priority encoding for the
// single-port SRAM scheduler (512x152 masked-write macro).
package sram_sched_pkg;

  localparam int DEF_DEPTH  = 512;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_WAYS   = 8;
  localparam int DEF_WAY_W  = 19;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic PRIO_RD = 1'b0;
  localparam logic PRIO_WR = 1'b1;

  // Requester slot positions in the arbiter req/gnt vectors.
  localparam int REQ_RD = 0;
  localparam int REQ_WR = 1;

endpackage

// File: rtl/sram_sched_rr.sv
// Two-requester round-robin arbiter: slot 0 is the reader, slot 1 the writer.
// After every grant the priority moves to the requester that did not win.
module sram_sched_rr
  import sram_sched_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       prio
);

  logic       prio_r;
  logic [1:0] gnt_s;

  // Grant decode: a lone requester wins, a contested cycle follows prio.
  always_comb begin
    gnt_s = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = (prio_r == PRIO_RD) ? 2'b01 : 2'b10;
        default: gnt_s = 2'b00;
      endcase
    end else begin
      gnt_s = 2'b00;
    end
  end

  // Priority register: hand priority to the loser of every grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_r <= PRIO_RD;
    end else if (gnt_s[REQ_RD]) begin
      prio_r <= PRIO_WR;
    end else if (gnt_s[REQ_WR]) begin
      prio_r <= PRIO_RD;
    end else begin
      prio_r <= prio_r;
    end
  end

  assign gnt  = gnt_s;
  assign prio = prio_r;

endmodule

// File: rtl/sram_port_sched.sv
// Shares the macro's single RW port between a reader and a masked writer.
// Define SRAM_SCHED_INIT_EN to zero-fill the array after reset and on flush_req.
module sram_port_sched
  import sram_sched_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WAYS   = DEF_WAYS,
  parameter int WAY_W  = DEF_WAY_W
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    resp_valid,
  output logic [WAYS*WAY_W-1:0]   resp_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [WAYS-1:0]         wr_mask,
  input  logic [WAYS*WAY_W-1:0]   wr_data,
  input  logic                    flush_req,
  output logic                    init_done,
  output logic                    sram_en,
  output logic                    sram_wmode,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [WAYS-1:0]         sram_wmask,
  output logic [WAYS*WAY_W-1:0]   sram_wdata,
  input  logic [WAYS*WAY_W-1:0]   sram_rdata
);

  localparam int DW = WAYS * WAY_W;

  logic [1:0]        req_s;
  logic [1:0]        gnt_s;
  logic              prio_unused_s;
  logic              init_done_r;
  logic              rd_pend_r;
  logic              resp_valid_r;
  logic [DW-1:0]     resp_data_r;
  logic              fill_s;
  logic [ADDR_W-1:0] fill_addr_s;

`ifdef SRAM_SCHED_INIT_EN
  state_e            state_r;
  state_e            state_nxt_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_nxt_s;

  // Sweep sequencing: flush restarts the fill from address 0 in either state.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_INIT: begin
        if (flush_req) begin
          cnt_nxt_s = {ADDR_W{1'b0}};
        end else if (cnt_r == ADDR_W'(DEPTH - 1)) begin
          cnt_nxt_s   = {ADDR_W{1'b0}};
          state_nxt_s = ST_RUN;
        end else begin
          cnt_nxt_s = cnt_r + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        if (flush_req) begin
          state_nxt_s = ST_INIT;
          cnt_nxt_s   = {ADDR_W{1'b0}};
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
        cnt_nxt_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // FSM, fill counter and ready flag registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_INIT;
      cnt_r       <= {ADDR_W{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      init_done_r <= (state_nxt_s == ST_RUN);
    end
  end

  // The sweep must not touch the macro while reset is held.
  assign fill_s      = (state_r == ST_INIT) && reset_n;
  assign fill_addr_s = cnt_r;
`else
  logic unused_s;

  // Without the fill, the block is ready one cycle after reset release.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      init_done_r <= 1'b0;
    end else begin
      init_done_r <= 1'b1;
    end
  end

  assign fill_s      = 1'b0;
  assign fill_addr_s = {ADDR_W{1'b0}};
  assign unused_s    = flush_req | (DEPTH == 0);
`endif

  assign req_s = {wr_valid, rd_valid};

  sram_sched_rr u_rr (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (init_done_r),
    .req     (req_s),
    .gnt     (gnt_s),
    .prio    (prio_unused_s)
  );

  assign rd_ready = gnt_s[REQ_RD];
  assign wr_ready = gnt_s[REQ_WR];

  // Macro port mux: fill sweep, granted read, granted write, or idle (all zero).
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = {ADDR_W{1'b0}};
    sram_wmask = {WAYS{1'b0}};
    sram_wdata = {DW{1'b0}};
    if (fill_s) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = fill_addr_s;
      sram_wmask = {WAYS{1'b1}};
    end else if (gnt_s[REQ_RD]) begin
      sram_en    = 1'b1;
      sram_addr  = rd_addr;
    end else if (gnt_s[REQ_WR]) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = wr_addr;
      sram_wmask = wr_mask;
      sram_wdata = wr_data;
    end else begin
      sram_en    = 1'b0;
    end
  end

  // Response capture: macro output is valid the cycle after the read accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_r    <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_data_r  <= {DW{1'b0}};
    end else begin
      rd_pend_r    <= gnt_s[REQ_RD];
      resp_valid_r <= rd_pend_r;
      if (rd_pend_r) begin
        resp_data_r <= sram_rdata;
      end else begin
        resp_data_r <= resp_data_r;
      end
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign init_done  = init_done_r;

endmodule

// File: tb/tb_sram_port_sched.sv
// Randomised bench for sram_port_sched against a behavioural model of the
// arbitration, memory contents and response timing; honours SRAM_SCHED_INIT_EN.
module tb_sram_port_sched;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;
  localparam int WAYS   = 8;
  localparam int WAY_W  = 19;
  localparam int DW     = WAYS * WAY_W;
`ifdef SRAM_SCHED_INIT_EN
  localparam int FLUSH_ODDS = 400;
`else
  localparam int FLUSH_ODDS = 7;
`endif

  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic              rd_valid, rd_ready, wr_valid, wr_ready;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              resp_valid;
  logic [DW-1:0]     resp_data;
  logic [WAYS-1:0]   wr_mask;
  logic [DW-1:0]     wr_data;
  logic              flush_req, init_done;
  logic              sram_en, sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [WAYS-1:0]   sram_wmask;
  logic [DW-1:0]     sram_wdata;
  logic [DW-1:0]     sram_rdata;

  always #5 clock = ~clock;

  sram_port_sched dut (
    .clock(clock), .reset_n(reset_n),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_mask(wr_mask), .wr_data(wr_data),
    .flush_req(flush_req), .init_done(init_done),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Macro stand-in: masked write, registered read with 1-cycle latency.
  logic [DW-1:0] sram_mem [DEPTH];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int w = 0; w < WAYS; w++)
          if (sram_wmask[w]) sram_mem[sram_addr][w*WAY_W +: WAY_W] <= sram_wdata[w*WAY_W +: WAY_W];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // Reference model state.
  typedef struct { int due; logic [DW-1:0] data; } resp_t;
  logic [DW-1:0] ref_mem [DEPTH];
  resp_t         rq[$];
  logic [DW-1:0] m_resp;
  bit            m_run, m_last_wr;
  int            m_fill, cyc, fill_cnt, done_cyc, resp_seen;
  int            total = 0;
  int            bad = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // One clock cycle: check outputs at the falling edge, then advance the model.
  task automatic run_cycle();
    logic exp_rd, exp_wr, exp_v, fill_now;
    @(negedge clock);
    exp_rd = 1'b0;
    exp_wr = 1'b0;
    fill_now = 1'b0;
`ifdef SRAM_SCHED_INIT_EN
    fill_now = !m_run;
`endif
    if (m_run) begin
      if (rd_valid && wr_valid) begin
        exp_rd = m_last_wr;
        exp_wr = !m_last_wr;
      end else begin
        exp_rd = rd_valid;
        exp_wr = wr_valid;
      end
    end
    check_eq("rd_ready", rd_ready, exp_rd);
    check_eq("wr_ready", wr_ready, exp_wr);
    check_eq("init_done", init_done, m_run);
    if (fill_now) begin
      check_eq("fill_en", {sram_en, sram_wmode}, 2'b11);
      check_eq("fill_addr", sram_addr, m_fill);
      check_eq("fill_mask", sram_wmask, 8'hFF);
      check_eq("fill_data", sram_wdata, 0);
    end else if (exp_rd) begin
      check_eq("rd_en", {sram_en, sram_wmode}, 2'b10);
      check_eq("rd_addr", sram_addr, rd_addr);
    end else if (exp_wr) begin
      check_eq("wr_en", {sram_en, sram_wmode}, 2'b11);
      check_eq("wr_addr", sram_addr, wr_addr);
      check_eq("wr_mask", sram_wmask, wr_mask);
      check_eq("wr_data", sram_wdata, wr_data);
    end else begin
      check_eq("idle_en", sram_en, 0);
      check_eq("idle_bus", {sram_addr, sram_wmask, sram_wdata}, 0);
    end
    exp_v = (rq.size() > 0) && (rq[0].due == cyc);
    if (exp_v) begin
      m_resp = rq[0].data;
      void'(rq.pop_front());
    end
    check_eq("resp_valid", resp_valid, exp_v);
    check_eq("resp_data", resp_data, m_resp);
    if (resp_valid) resp_seen++;
    if (init_done && done_cyc == 0) done_cyc = cyc;
    if (sram_en && sram_wmode && !init_done) fill_cnt++;
    if (exp_rd) begin
      rq.push_back('{cyc + 2, ref_mem[rd_addr]});
      m_last_wr = 1'b0;
    end
    if (exp_wr) begin
      for (int w = 0; w < WAYS; w++)
        if (wr_mask[w]) ref_mem[wr_addr][w*WAY_W +: WAY_W] = wr_data[w*WAY_W +: WAY_W];
      m_last_wr = 1'b1;
    end
`ifdef SRAM_SCHED_INIT_EN
    if (fill_now) begin
      ref_mem[m_fill] = '0;
      if (flush_req) m_fill = 0;
      else if (m_fill == DEPTH - 1) begin m_fill = 0; m_run = 1'b1; end
      else m_fill++;
    end else if (flush_req) begin
      m_run = 1'b0;
      m_fill = 0;
    end
`else
    m_run = 1'b1;
`endif
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Asynchronous reset with requests active; outputs must show reset values.
  task automatic apply_reset();
    reset_n = 1'b0;
    rd_valid = 1'b1; wr_valid = 1'b1; flush_req = 1'b1;
    wr_mask = 8'hFF; wr_data = rnd_data();
    #2;
    check_eq("rst_sram", {sram_en, sram_wmode, sram_addr}, 0);
    check_eq("rst_resp", {resp_valid, resp_data}, 0);
    check_eq("rst_flags", {init_done, rd_ready, wr_ready}, 0);
    @(posedge clock);
    #1;
    rd_valid = 1'b0; wr_valid = 1'b0; flush_req = 1'b0;
    reset_n = 1'b1;
    rq.delete();
    m_resp = '0; m_last_wr = 1'b1; m_run = 1'b0; m_fill = 0;
    cyc = 1; fill_cnt = 0; done_cyc = 0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [WAYS-1:0] m, input logic [DW-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_mask = m; wr_data = d;
    run_cycle();
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    rd_valid = 1'b1; rd_addr = a;
    run_cycle();
    rd_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic wait_filled();
    for (int i = 0; i < 600 && !m_run; i++) run_cycle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] v1, v2, v3, exp_m, abc;
    int base;
    rd_valid = 1'b0; wr_valid = 1'b0; flush_req = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_mask = '0; wr_data = '0;
    resp_seen = 0; m_resp = '0;
    #1;
    apply_reset();

`ifdef SRAM_SCHED_INIT_EN
    wait_filled();
    check_eq("fill_count", fill_cnt, 512);
    run_cycle();
    check_eq("done_cycle", done_cyc, 513);
`else
    run_cycle();
    for (int a = 0; a < DEPTH; a++) do_write(ADDR_W'(a), 8'hFF, '0);
`endif
    do_read(9'd5);
    idle(3);
    check_eq("read5_zero", resp_data, 0);

    // Masked write then read-after-write.
    do_write(9'h1A5, 8'h81, {DW{1'b1}});
    do_read(9'h1A5);
    idle(3);
    exp_m = '0;
    exp_m[WAY_W-1:0] = {WAY_W{1'b1}};
    exp_m[DW-1 -: WAY_W] = {WAY_W{1'b1}};
    check_eq("masked_data", resp_data, exp_m);

    // Contested stream after a write grant.
    do_write(9'd0, 8'hFF, '0);
    base = resp_seen;
    for (int i = 0; i < 6; i++) begin
      rd_valid = 1'b1; wr_valid = 1'b1;
      rd_addr = ADDR_W'($urandom_range(16, 31));
      wr_addr = ADDR_W'($urandom_range(16, 31));
      wr_mask = WAYS'($urandom_range(0, 255));
      wr_data = rnd_data();
      run_cycle();
    end
    rd_valid = 1'b0; wr_valid = 1'b0;
    idle(3);
    check_eq("contest_resps", resp_seen - base, 3);

    // Back-to-back reads.
    v1 = rnd_data(); v2 = rnd_data(); v3 = rnd_data();
    do_write(9'd1, 8'hFF, v1);
    do_write(9'd2, 8'hFF, v2);
    do_write(9'd3, 8'hFF, v3);
    base = resp_seen;
    do_read(9'd1); do_read(9'd2); do_read(9'd3);
    idle(4);
    check_eq("b2b_resps", resp_seen - base, 3);
    check_eq("hold_addr3", resp_data, v3);

    // Random traffic on a small address window.
    for (int i = 0; i < 1500; i++) begin
      rd_valid = 1'($urandom_range(0, 1));
      wr_valid = 1'($urandom_range(0, 1));
      rd_addr = ADDR_W'($urandom_range(0, 15));
      wr_addr = ADDR_W'($urandom_range(0, 15));
      wr_mask = WAYS'($urandom_range(0, 255));
      wr_data = rnd_data();
      flush_req = ($urandom_range(0, FLUSH_ODDS) == 0);
      run_cycle();
      flush_req = 1'b0;
      if (!m_run) wait_filled();
    end
    rd_valid = 1'b0; wr_valid = 1'b0;
    idle(3);

`ifdef SRAM_SCHED_INIT_EN
    // Flush together with a read accept: the read still returns old data.
    abc = {WAYS{19'hABC}};
    do_write(9'd7, 8'hFF, abc);
    fill_cnt = 0;
    rd_valid = 1'b1; rd_addr = 9'd7; flush_req = 1'b1;
    run_cycle();
    rd_valid = 1'b0; flush_req = 1'b0;
    wait_filled();
    check_eq("flush_fill_count", fill_cnt, 512);
    check_eq("flush_rd_data", resp_data, abc);
    run_cycle();
`else
    abc = '0;
`endif

    // Reset with a read pending drops the response.
    do_read(9'd9);
    apply_reset();
`ifdef SRAM_SCHED_INIT_EN
    idle(300);
    check_eq("mid_fill_addr", m_fill, 300);
    apply_reset();
    wait_filled();
    check_eq("refill_count", fill_cnt, 512);
    run_cycle();
`else
    base = resp_seen;
    idle(5);
    check_eq("dropped_resp", resp_seen - base, 0);
`endif
    do_read(9'd2);
    idle(3);
    check_eq("post_reset_read", resp_data, ref_mem[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
